// File: rtl/alu_pkg.sv
// Shared types, widths and single-cycle ALU evaluation for the ALU command responder.
package alu_pkg;

  localparam int unsigned A_W  = 8;
  localparam int unsigned B_W  = 5;
  localparam int unsigned OP_W = 3;
  localparam int unsigned P_W  = A_W + B_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic [A_W-1:0] result;
    logic           carry;
  } alu_res_t;

  // MUL here is the disabled-multiplier response; the sequential path overrides it when built in.
  function automatic alu_res_t alu_single(input logic [A_W-1:0] a,
                                          input logic [B_W-1:0] b,
                                          input alu_op_e        op);
    alu_res_t       res;
    logic [A_W:0]   sum;
    logic [A_W-1:0] b8;
    b8         = A_W'(b);
    sum        = '0;
    res.result = '0;
    res.carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum        = {1'b0, a} + {1'b0, b8};
        res.result = sum[A_W-1:0];
        res.carry  = sum[A_W];
      end
      OP_SUB: begin
        res.result = a - b8;
        res.carry  = (a < b8);
      end
      OP_AND:  res.result = a & b8;
      OP_OR:   res.result = a | b8;
      OP_XOR:  res.result = a ^ b8;
      OP_SHL:  res.result = a << b[2:0];
      OP_MUL: begin
        res.result = '0;
        res.carry  = 1'b1;
      end
      default: res.result = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: first partial product on start, then one per cycle; done pulses with the final product.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           done,
  output logic [P_W-1:0] product
);

  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] r_mcand;
  logic [B_W-1:0] r_mplier;
  logic [2:0]     r_cnt;
  logic           r_busy;
  logic           r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc    <= b[0] ? P_W'(a) : '0;
        r_mcand  <= P_W'(a) << 1;
        r_mplier <= b >> 1;
        r_cnt    <= 3'd1;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 3'd1;
        // Iteration index B_W-1 is the last multiplier bit.
        if (r_cnt == 3'(B_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule

// File: rtl/alu_cmd_responder.sv
// Valid/ready ALU command responder with a one-cycle result strobe.
// ALU_MUL_EN builds in the sequential multiplier; otherwise opcode 110 answers at once with result 0, carry 1.
module alu_cmd_responder
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [A_W-1:0]  a_i,
  input  logic [B_W-1:0]  b_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  output logic            rsp_valid_o,
  output logic [A_W-1:0]  result_o,
  output logic            carry_o,
  output logic            zero_o
);

  alu_state_e     r_state;
  logic           r_ready;
  logic           r_rsp;
  logic [A_W-1:0] r_result;
  logic           r_carry;
  logic           r_zero;

  logic           w_accept;
  alu_op_e        w_op;
  alu_res_t       w_res;

  assign w_op     = alu_op_e'(op_i);
  assign w_accept = (r_state == ST_IDLE) && cmd_valid_i && r_ready;
  assign w_res    = alu_single(a_i, b_i, w_op);

`ifdef ALU_MUL_EN
  logic           w_mul_start;
  logic           w_mul_done;
  logic [P_W-1:0] w_product;

  assign w_mul_start = w_accept && (w_op == OP_MUL);

  alu_mul_seq u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (a_i),
    .b       (b_i),
    .done    (w_mul_done),
    .product (w_product)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_rsp    <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
`ifdef ALU_MUL_EN
            if (w_op == OP_MUL) begin
              r_state <= ST_EXEC;
            end else begin
              r_state  <= ST_DONE;
              r_rsp    <= 1'b1;
              r_result <= w_res.result;
              r_carry  <= w_res.carry;
              r_zero   <= (w_res.result == '0);
            end
`else
            r_state  <= ST_DONE;
            r_rsp    <= 1'b1;
            r_result <= w_res.result;
            r_carry  <= w_res.carry;
            r_zero   <= (w_res.result == '0);
`endif
          end
        end
`ifdef ALU_MUL_EN
        ST_EXEC: begin
          if (w_mul_done) begin
            r_state  <= ST_DONE;
            r_rsp    <= 1'b1;
            r_result <= w_product[A_W-1:0];
            r_carry  <= |w_product[P_W-1:A_W];
            r_zero   <= (w_product[A_W-1:0] == '0);
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_rsp   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rsp   <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign rsp_valid_o = r_rsp;
  assign result_o    = r_result;
  assign carry_o     = r_carry;
  assign zero_o      = r_zero;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed-vector bench for alu_cmd_responder; expectations follow the build's ALU_MUL_EN setting.
module tb_alu_cmd_responder;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_i;
  logic [4:0] b_i;
  logic [2:0] op_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       rsp_valid_o;
  logic [7:0] result_o;
  logic       carry_o;
  logic       zero_o;

  int n_vec  = 0;
  int n_miss = 0;

  alu_cmd_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .zero_o      (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one command, wait (bounded) for rsp_valid; with hold set, cmd_valid stays up carrying ADD 0xAA+1.
  task automatic issue(input string tag, input logic [7:0] a, input logic [4:0] b,
                       input logic [2:0] op, input bit hold, output int lat);
    bit ready_seen;
    @(negedge clk);
    a_i = a; b_i = b; op_i = op; cmd_valid_i = 1'b1;
    chk({tag, "_ready_pre"}, 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      a_i = 8'hAA; b_i = 5'h01; op_i = OP_ADD;
    end else begin
      cmd_valid_i = 1'b0;
    end
    lat = 1;
    ready_seen = 1'b0;
    while (!rsp_valid_o && lat < 20) begin
      if (cmd_ready_o) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_ready_busy"}, 32'(ready_seen | cmd_ready_o), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input int lat, input logic [7:0] res,
                           input logic c, input logic z, input int exp_lat);
    chk({tag, "_lat"},    32'(lat),      32'(exp_lat));
    chk({tag, "_result"}, 32'(result_o), 32'(res));
    chk({tag, "_carry"},  32'(carry_o),  32'(c));
    chk({tag, "_zero"},   32'(zero_o),   32'(z));
  endtask

  // Response strobe must last exactly one cycle and ready must return.
  task automatic check_release(input string tag);
    @(posedge clk); #1;
    chk({tag, "_rsp_drop"},  32'(rsp_valid_o), 32'd0);
    chk({tag, "_ready_ret"}, 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  mul_lat;
    mul_lat = MUL_EN ? 6 : 1;
    rst_n = 1'b0; a_i = '0; b_i = '0; op_i = '0; cmd_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_result", 32'(result_o),    32'd0);
    chk("rst_carry",  32'(carry_o),     32'd0);
    chk("rst_zero",   32'(zero_o),      32'd1);
    chk("rst_rsp",    32'(rsp_valid_o), 32'd0);
    chk("rst_ready",  32'(cmd_ready_o), 32'd1);

    issue("add3_5", 8'd3, 5'd5, OP_ADD, 1'b0, lat);
    check_rsp("add3_5", lat, 8'd8, 1'b0, 1'b0, 1);
    check_release("add3_5");

    issue("add250_10", 8'd250, 5'd10, OP_ADD, 1'b0, lat);
    check_rsp("add250_10", lat, 8'd4, 1'b1, 1'b0, 1);
    check_release("add250_10");

    issue("sub3_5", 8'd3, 5'd5, OP_SUB, 1'b0, lat);
    check_rsp("sub3_5", lat, 8'hFE, 1'b1, 1'b0, 1);
    check_release("sub3_5");

    issue("mul20_13", 8'd20, 5'd13, OP_MUL, 1'b0, lat);
    check_rsp("mul20_13", lat, MUL_EN ? 8'h04 : 8'h00, 1'b1, MUL_EN ? 1'b0 : 1'b1, mul_lat);
    check_release("mul20_13");

    // Command held valid through the busy period must wait for IDLE.
    issue("mul_hold", 8'd7, 5'd3, OP_MUL, 1'b1, lat);
    check_rsp("mul_hold", lat, MUL_EN ? 8'd21 : 8'd0, MUL_EN ? 1'b0 : 1'b1,
              MUL_EN ? 1'b0 : 1'b1, mul_lat);
    check_release("mul_hold");
    @(posedge clk); #1;
    chk("hold_next_rsp",    32'(rsp_valid_o), 32'd1);
    chk("hold_next_result", 32'(result_o),    32'hAB);
    chk("hold_next_ready",  32'(cmd_ready_o), 32'd0);
    cmd_valid_i = 1'b0;
    check_release("hold_next");

    issue("shl4", 8'h0F, 5'h1C, OP_SHL, 1'b0, lat);
    check_rsp("shl4", lat, 8'hF0, 1'b0, 1'b0, 1);
    check_release("shl4");

    issue("xor_eq", 8'h05, 5'h05, OP_XOR, 1'b0, lat);
    check_rsp("xor_eq", lat, 8'h00, 1'b0, 1'b1, 1);
    check_release("xor_eq");

    issue("shl0", 8'h5A, 5'h08, OP_SHL, 1'b0, lat);
    check_rsp("shl0", lat, 8'h5A, 1'b0, 1'b0, 1);
    check_release("shl0");

    issue("mul_b0", 8'h99, 5'h00, OP_MUL, 1'b0, lat);
    check_rsp("mul_b0", lat, 8'h00, MUL_EN ? 1'b0 : 1'b1, 1'b1, mul_lat);
    check_release("mul_b0");

    issue("and", 8'hF3, 5'h15, OP_AND, 1'b0, lat);
    check_rsp("and", lat, 8'h11, 1'b0, 1'b0, 1);
    check_release("and");

    issue("or", 8'h40, 5'h1F, OP_OR, 1'b0, lat);
    check_rsp("or", lat, 8'h5F, 1'b0, 1'b0, 1);
    check_release("or");

    issue("pass", 8'h77, 5'h03, OP_PASS, 1'b0, lat);
    check_rsp("pass", lat, 8'h77, 1'b0, 1'b0, 1);
    check_release("pass");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", 32'(result_o), 32'h77);
    chk("hold_rsp",    32'(rsp_valid_o), 32'd0);

    // Reset during the third EXEC cycle (right after accept when MUL is not built).
    @(negedge clk);
    a_i = 8'd20; b_i = 5'd13; op_i = OP_MUL; cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (MUL_EN ? 2 : 0) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #2;
    chk("mid_rst_result", 32'(result_o),    32'd0);
    chk("mid_rst_zero",   32'(zero_o),      32'd1);
    chk("mid_rst_carry",  32'(carry_o),     32'd0);
    chk("mid_rst_rsp",    32'(rsp_valid_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid_o) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", 32'(seen),        32'd0);
    chk("mid_rst_ready",  32'(cmd_ready_o), 32'd1);
    chk("mid_rst_res2",   32'(result_o),    32'd0);

    issue("post_rst_add", 8'd1, 5'd1, OP_ADD, 1'b0, lat);
    check_rsp("post_rst_add", lat, 8'd2, 1'b0, 1'b0, 1);
    check_release("post_rst_add");

    issue("mul_max", 8'hFF, 5'h1F, OP_MUL, 1'b0, lat);
    check_rsp("mul_max", lat, MUL_EN ? 8'hE1 : 8'h00, 1'b1, MUL_EN ? 1'b0 : 1'b1, mul_lat);
    check_release("mul_max");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
